// File: rtl/evm_result_reader.sv
// evm_result_reader
// Readout companion for the EVM voting controller. After a session closes it
// walks the controller's result selects (three candidates, then the winner),
// captures each record and ships it as an 8N1 UART byte stream:
//   per record: header {4'b1010, name, invalid, winner}, then value byte.
// Optional feature macro: EVM_RDR_CHECKSUM_EN
//   defined   -> a ninth byte (XOR of the eight record bytes) closes the frame
//   undefined -> eight-byte frame, no checksum register
module evm_result_reader #(
    parameter int WIDTH        = 7,
    parameter int CLKS_PER_BIT = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       evm_candidate_name,
    input  logic             evm_invalid_results,
    input  logic [WIDTH-1:0] evm_results,
    output logic [1:0]       display_results,
    output logic             display_winner,
    output logic             tx,
    output logic             busy,
    output logic             done
);

    // Parameter sanity: counts must fit the 8-bit value byte, and a bit must
    // last at least two cycles.
    generate
        if (WIDTH > 8) begin : g_bad_width
            $error("evm_result_reader: WIDTH must be <= 8");
        end
        if (CLKS_PER_BIT < 2) begin : g_bad_baud
            $error("evm_result_reader: CLKS_PER_BIT must be >= 2");
        end
    endgenerate

    localparam int            CW       = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        IDLE,
        SELECT,
        SETTLE,
        TX_START,
        TX_DATA,
        TX_STOP,
        DONE
    } state_t;

    typedef enum logic [1:0] {
        BYTE_HDR,
        BYTE_VAL,
        BYTE_CHK
    } byte_t;

    state_t        state_reg;
    byte_t         byte_reg;
    logic [1:0]    rec_reg;
    logic [CW-1:0] cnt_reg;
    logic [2:0]    bit_reg;
    logic [7:0]    shift_reg;
    logic [7:0]    val_reg;
`ifdef EVM_RDR_CHECKSUM_EN
    logic [7:0]    chk_reg;
`endif

    logic [7:0]    val_ext;
    logic [7:0]    hdr_next;
    logic [1:0]    rec_inc;

    // Zero-extend the controller count to a full value byte.
    generate
        for (genvar gi = 0; gi < 8; gi++) begin : g_val_ext
            if (gi < WIDTH) begin : g_bit
                assign val_ext[gi] = evm_results[gi];
            end else begin : g_pad
                assign val_ext[gi] = 1'b0;
            end
        end
    endgenerate

    // Header for the record currently selected; the winner flag marks r == 3.
    assign hdr_next = {4'b1010, evm_candidate_name, evm_invalid_results, (rec_reg == 2'd3)};
    assign rec_inc  = rec_reg + 2'd1;

    // Readout sequencer and UART transmitter; every output is a register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg       <= IDLE;
            byte_reg        <= BYTE_HDR;
            rec_reg         <= 2'd0;
            cnt_reg         <= '0;
            bit_reg         <= 3'd0;
            shift_reg       <= 8'd0;
            val_reg         <= 8'd0;
`ifdef EVM_RDR_CHECKSUM_EN
            chk_reg         <= 8'd0;
`endif
            display_results <= 2'b00;
            display_winner  <= 1'b0;
            tx              <= 1'b1;
            busy            <= 1'b0;
            done            <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state_reg)
                IDLE: begin
                    tx   <= 1'b1;
                    busy <= 1'b0;
                    if (start) begin
                        state_reg       <= SELECT;
                        rec_reg         <= 2'd0;
                        busy            <= 1'b1;
                        display_results <= 2'b00;
                        display_winner  <= 1'b0;
`ifdef EVM_RDR_CHECKSUM_EN
                        chk_reg         <= 8'd0;
`endif
                    end
                end

                // Selects were driven on entry; give the controller a cycle.
                SELECT: begin
                    state_reg <= SETTLE;
                end

                // Capture the record and launch its header start bit.
                SETTLE: begin
                    shift_reg <= hdr_next;
                    val_reg   <= val_ext;
`ifdef EVM_RDR_CHECKSUM_EN
                    chk_reg   <= chk_reg ^ hdr_next ^ val_ext;
`endif
                    byte_reg  <= BYTE_HDR;
                    cnt_reg   <= '0;
                    tx        <= 1'b0;
                    state_reg <= TX_START;
                end

                TX_START: begin
                    if (cnt_reg == CNT_LAST) begin
                        cnt_reg   <= '0;
                        bit_reg   <= 3'd0;
                        tx        <= shift_reg[0];
                        state_reg <= TX_DATA;
                    end else begin
                        cnt_reg <= cnt_reg + 1'b1;
                    end
                end

                // Data bits LSB first; shift_reg[0] is always the bit on the line.
                TX_DATA: begin
                    if (cnt_reg == CNT_LAST) begin
                        cnt_reg <= '0;
                        if (bit_reg == 3'd7) begin
                            tx        <= 1'b1;
                            state_reg <= TX_STOP;
                        end else begin
                            bit_reg   <= bit_reg + 3'd1;
                            tx        <= shift_reg[1];
                            shift_reg <= {1'b0, shift_reg[7:1]};
                        end
                    end else begin
                        cnt_reg <= cnt_reg + 1'b1;
                    end
                end

                // End of a byte: chain the next byte with no gap, move to the
                // next record, or close the frame.
                TX_STOP: begin
                    if (cnt_reg == CNT_LAST) begin
                        cnt_reg <= '0;
                        case (byte_reg)
                            BYTE_HDR: begin
                                shift_reg <= val_reg;
                                byte_reg  <= BYTE_VAL;
                                tx        <= 1'b0;
                                state_reg <= TX_START;
                            end
                            BYTE_VAL: begin
                                if (rec_reg != 2'd3) begin
                                    rec_reg         <= rec_inc;
                                    display_results <= (rec_inc == 2'd3) ? 2'b00 : rec_inc;
                                    display_winner  <= (rec_inc == 2'd3);
                                    state_reg       <= SELECT;
                                end else begin
`ifdef EVM_RDR_CHECKSUM_EN
                                    shift_reg <= chk_reg;
                                    byte_reg  <= BYTE_CHK;
                                    tx        <= 1'b0;
                                    state_reg <= TX_START;
`else
                                    done            <= 1'b1;
                                    display_results <= 2'b00;
                                    display_winner  <= 1'b0;
                                    state_reg       <= DONE;
`endif
                                end
                            end
                            default: begin
                                done            <= 1'b1;
                                display_results <= 2'b00;
                                display_winner  <= 1'b0;
                                state_reg       <= DONE;
                            end
                        endcase
                    end else begin
                        cnt_reg <= cnt_reg + 1'b1;
                    end
                end

                DONE: begin
                    busy      <= 1'b0;
                    state_reg <= IDLE;
                end

                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_evm_result_reader.sv
// Directed bench for evm_result_reader with a behavioural controller model.
// Honours EVM_RDR_CHECKSUM_EN for frame length, checksum byte and done timing.
module tb_evm_result_reader;

    localparam int W = 7;
    localparam int C = 4;
`ifdef EVM_RDR_CHECKSUM_EN
    localparam int NBYTES   = 9;
    localparam int DONE_REL = 8 + 90 * C;
`else
    localparam int NBYTES   = 8;
    localparam int DONE_REL = 8 + 80 * C;
`endif
    localparam int REC_PERIOD = 2 + 20 * C;

    logic         clk   = 1'b0;
    logic         rst   = 1'b0;
    logic         start = 1'b0;
    logic [1:0]   evm_candidate_name;
    logic         evm_invalid_results;
    logic [W-1:0] evm_results;
    logic [1:0]   display_results;
    logic         display_winner;
    logic         tx;
    logic         busy;
    logic         done;

    int n_checks = 0;
    int n_fail   = 0;

    logic [W-1:0] cnt0 = '0;
    logic [W-1:0] cnt1 = '0;
    logic [W-1:0] cnt2 = '0;
    logic         corrupt = 1'b0;

    logic [7:0] got_bytes [16];
    int         ngot;
    int         done_rel;
    int         done_cnt;
    logic [7:0] exp_bytes [9];

    always #5 clk = ~clk;

    evm_result_reader #(.WIDTH(W), .CLKS_PER_BIT(C)) dut (
        .clk                 (clk),
        .rst                 (rst),
        .start               (start),
        .evm_candidate_name  (evm_candidate_name),
        .evm_invalid_results (evm_invalid_results),
        .evm_results         (evm_results),
        .display_results     (display_results),
        .display_winner      (display_winner),
        .tx                  (tx),
        .busy                (busy),
        .done                (done)
    );

    // Controller: names 1..3 for candidates, winner select reports the
    // strict maximum; any tie for the top gives invalid=1, name=0, results=0.
    function automatic logic [W+2:0] ctrl_model(input logic [1:0] sel, input logic win,
                                                 input logic [W-1:0] c0, input logic [W-1:0] c1,
                                                 input logic [W-1:0] c2);
        logic [1:0]   wn;
        logic [W-1:0] wc;
        logic         tie;
        wn = 2'd0; wc = '0; tie = 1'b0;
        if (c0 > c1 && c0 > c2) begin wn = 2'd1; wc = c0; end
        else if (c1 > c0 && c1 > c2) begin wn = 2'd2; wc = c1; end
        else if (c2 > c0 && c2 > c1) begin wn = 2'd3; wc = c2; end
        else tie = 1'b1;
        if (tie) return {2'b00, 1'b1, {W{1'b0}}};
        if (win) return {wn, 1'b0, wc};
        case (sel)
            2'd0:    return {2'd1, 1'b0, c0};
            2'd1:    return {2'd2, 1'b0, c1};
            default: return {2'd3, 1'b0, c2};
        endcase
    endfunction

    assign {evm_candidate_name, evm_invalid_results, evm_results} =
        ctrl_model(display_results, display_winner, cnt0, cnt1, cnt2) ^ (corrupt ? 10'h3D5 : 10'h000);

    // Pulse start, then decode the UART line at negedges until done plus a tail.
    // mode 1 adds a second start mid byte 2 and corrupts evm_* after a capture.
    task automatic collect_frame(input int mode);
        int rel;
        int s;
        int k;
        int r;
        logic [7:0] sh;
        ngot = 0; done_rel = -1; done_cnt = 0; s = -1; sh = 8'h00;
        for (int i = 0; i < 16; i++) got_bytes[i] = 8'h00;
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        rel = 0;
        n_checks++;
        if ({busy, display_results, display_winner} !== 4'b1000) begin
            n_fail++;
            $display("FAIL busy_after_start: got busy=%b sel=%0d win=%b, want busy=1 sel=0 win=0",
                     busy, display_results, display_winner);
        end
        while (rel < 3000) begin
            if (mode == 1) begin
                if (rel == 50) start = 1'b1;
                if (rel == 51) start = 1'b0;
                corrupt = (rel >= 60 && rel < 80);
            end
            if (s < 0) begin
                if (tx === 1'b0) begin
                    s = rel;
                    if (ngot < 8 && (ngot % 2) == 0) begin
                        r = ngot / 2;
                        n_checks++;
                        if (s != 2 + r * REC_PERIOD) begin
                            n_fail++;
                            $display("FAIL hdr_timing r=%0d: start bit at E+%0d, want E+%0d", r, s, 2 + r * REC_PERIOD);
                        end
                        n_checks++;
                        if (display_results !== ((r == 3) ? 2'd0 : 2'(r)) || display_winner !== (r == 3)) begin
                            n_fail++;
                            $display("FAIL select r=%0d: got sel=%0d win=%b, want sel=%0d win=%b",
                                     r, display_results, display_winner, (r == 3) ? 0 : r, (r == 3));
                        end
                    end
                end
            end else begin
                k = rel - s;
                if ((k % C) == C / 2) begin
                    if (k / C == 0) begin
                        n_checks++;
                        if (tx !== 1'b0) begin
                            n_fail++;
                            $display("FAIL start_bit byte %0d: got %b want 0", ngot, tx);
                        end
                    end else if (k / C <= 8) begin
                        sh[k / C - 1] = tx;
                    end else begin
                        n_checks++;
                        if (tx !== 1'b1) begin
                            n_fail++;
                            $display("FAIL stop_bit byte %0d: got %b want 1", ngot, tx);
                        end
                        if (ngot < 16) got_bytes[ngot] = sh;
                        ngot++;
                        s = -1;
                    end
                end
            end
            if (done === 1'b1) begin
                if (done_cnt == 0) done_rel = rel;
                done_cnt++;
            end
            if (done_cnt > 0 && rel == done_rel + 1) begin
                n_checks++;
                if (busy !== 1'b0) begin
                    n_fail++;
                    $display("FAIL busy_fall: got %b want 0 one cycle after done", busy);
                end
            end
            if (done_cnt > 0 && rel >= done_rel + 20) break;
            @(negedge clk);
            rel++;
        end
        corrupt = 1'b0;
        n_checks++;
        if (done_cnt == 0) begin
            n_fail++;
            $display("FAIL frame_timeout: no done within %0d cycles, want done at E+%0d", rel, DONE_REL);
        end
        n_checks++;
        if ({tx, busy} !== 2'b10) begin
            n_fail++;
            $display("FAIL idle_after_frame: got tx=%b busy=%b want tx=1 busy=0", tx, busy);
        end
    endtask

    // Compare the collected frame against exp_bytes.
    task automatic check_frame(input string tag);
        n_checks++;
        if (ngot != NBYTES) begin
            n_fail++;
            $display("FAIL %s byte_count: got %0d want %0d", tag, ngot, NBYTES);
        end
        for (int i = 0; i < NBYTES; i++) begin
            n_checks++;
            if (got_bytes[i] !== exp_bytes[i]) begin
                n_fail++;
                $display("FAIL %s byte%0d: got %02h want %02h", tag, i, got_bytes[i], exp_bytes[i]);
            end
        end
        n_checks++;
        if (done_rel != DONE_REL || done_cnt != 1) begin
            n_fail++;
            $display("FAIL %s done: got E+%0d (x%0d) want E+%0d (x1)", tag, done_rel, done_cnt, DONE_REL);
        end
        $display("%s: %0d bytes, done at E+%0d", tag, ngot, done_rel);
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        n_checks++;
        if ({tx, busy, done, display_results, display_winner} !== 6'b100000) begin
            n_fail++;
            $display("FAIL reset_values: got tx=%b busy=%b done=%b sel=%0d win=%b want 1 0 0 0 0",
                     tx, busy, done, display_results, display_winner);
        end
        rst = 1'b1;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            n_checks++;
            if ({tx, busy, done, display_results, display_winner} !== 6'b100000) begin
                n_fail++;
                $display("FAIL idle_cycle%0d: got tx=%b busy=%b done=%b sel=%0d win=%b want 1 0 0 0 0",
                         i, tx, busy, done, display_results, display_winner);
            end
        end
        $display("reset: idle 50 cycles checked");
    endtask

    task automatic test_results_531();
        cnt0 = 7'd5; cnt1 = 7'd3; cnt2 = 7'd1;
        exp_bytes = '{8'hA4, 8'h05, 8'hA8, 8'h03, 8'hAC, 8'h01, 8'hA5, 8'h05, 8'h07};
        collect_frame(0);
        check_frame("results_531");
    endtask

    task automatic test_tie_442();
        cnt0 = 7'd4; cnt1 = 7'd4; cnt2 = 7'd2;
        exp_bytes = '{8'hA2, 8'h00, 8'hA2, 8'h00, 8'hA2, 8'h00, 8'hA3, 8'h00, 8'h01};
        collect_frame(0);
        check_frame("tie_442");
    endtask

    task automatic test_disturbed();
        cnt0 = 7'd5; cnt1 = 7'd3; cnt2 = 7'd1;
        exp_bytes = '{8'hA4, 8'h05, 8'hA8, 8'h03, 8'hAC, 8'h01, 8'hA5, 8'h05, 8'h07};
        collect_frame(1);
        check_frame("disturbed_531");
    endtask

    task automatic test_reset_mid_frame();
        cnt0 = 7'd2; cnt1 = 7'd9; cnt2 = 7'd6;
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        repeat (130) @(negedge clk);
        rst = 1'b0;
        #1;
        n_checks++;
        if ({tx, busy, done, display_results, display_winner} !== 6'b100000) begin
            n_fail++;
            $display("FAIL midframe_reset: got tx=%b busy=%b done=%b sel=%0d win=%b want 1 0 0 0 0",
                     tx, busy, done, display_results, display_winner);
        end
        repeat (3) @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            n_checks++;
            if ({tx, busy, done} !== 3'b100) begin
                n_fail++;
                $display("FAIL no_resume%0d: got tx=%b busy=%b done=%b want 1 0 0", i, tx, busy, done);
            end
        end
        // 2/9/6: candidate 2 (name 2) wins with 9; checksum A4^A8^AC^A9 ^ 02^09^06^09 = 0D
        exp_bytes = '{8'hA4, 8'h02, 8'hA8, 8'h09, 8'hAC, 8'h06, 8'hA9, 8'h09, 8'h0D};
        collect_frame(0);
        check_frame("after_reset_296");
    endtask

    initial begin
        test_reset();
        test_results_531();
        test_tie_442();
        test_disturbed();
        test_reset_mid_frame();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
